// File: rtl/serial_add_ctrl_if.sv
// Bundle of requester handshakes, operands, results and the serial-adder
// control/data lines shared by the controller and its environment.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;

  // Environment side: requesters plus the serial adder's sum.
  modport master (
    output req0, a0, b0, req1, a1, b1, sum,
    input  gnt, done, result, load, shift, add_a, add_b
  );

  // Controller side.
  modport slave (
    input  req0, a0, b0, req1, a1, b1, sum,
    output gnt, done, result, load, shift, add_a, add_b
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Two-requester round-robin controller for a bit-serial adder.
// Sequence per operation: accept (capture operands) -> one LOAD cycle ->
// WIDTH shift cycles -> one settle cycle while the adder's sum becomes
// valid -> DONE (result captured, one-cycle done pulse) -> IDLE.
// The SHIFT state counts completed shifts; it stays one extra cycle after
// the last shift (count == WIDTH) so that the sum sampled on entry to DONE
// is the finished one. done therefore rises WIDTH+2 edges after accept.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          reset,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             ptr;      // favoured requester on a tie
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic             load_q;
  logic             shift_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result_q;
  logic             pick1;

  // Requester 1 wins when it is alone or when it is favoured on a tie.
  assign pick1 = bus.req1 && (!bus.req0 || ptr);

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state  <= LOAD;
            load_q <= 1'b1;
            if (pick1) begin
              gnt_q <= 2'b10;
              op_a  <= bus.a1;
              op_b  <= bus.b1;
            end else begin
              gnt_q <= 2'b01;
              op_a  <= bus.a0;
              op_b  <= bus.b0;
            end
          end
        end
        LOAD: begin
          state   <= SHIFT;
          load_q  <= 1'b0;
          shift_q <= 1'b1;
          cnt     <= '0;
        end
        SHIFT: begin
          if (cnt == CW'(WIDTH)) begin
            state    <= DONE;
            cnt      <= '0;
            done_q   <= gnt_q;
            result_q <= bus.sum;
            ptr      <= gnt_q[0];   // hand priority to the other requester
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) shift_q <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.load   = load_q;
  assign bus.shift  = shift_q;
  assign bus.add_a  = op_a;
  assign bus.add_b  = op_b;
endmodule
